// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared state encoding and ALU op codes for the bit-serial sequencer
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/ula_bit_shreg.sv
// rtl/ula_bit_shreg.sv - W-bit shift register with parallel load, shift-right and serial-in
module ula_bit_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {sin, q[W-1:1]};
        end
    end

endmodule

// File: rtl/ula_serial_seq.sv
// rtl/ula_serial_seq.sv - LSB-first operand sequencer around a 1-bit ALU
// Optional macro SERIAL_OVF_EN adds the signed-overflow output ovf.
module ula_serial_seq
    import ula_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    input  logic [1:0]   opSel,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         A,
    output logic         B,
    output logic         carryIn,
    output logic [1:0]   op,
    input  logic         C,
    input  logic         carryOut
`ifdef SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = $clog2(W + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] counter;
    logic             carry_q;
    logic             accept;
    logic             cap;
    logic             last;
    logic [W-1:0]     sh_a;
    logic [W-1:0]     sh_b;
    logic             unused_bits;

    assign last = (counter == CNT_W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A start is honoured in IDLE and in DONE (back-to-back); RUN ignores it.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cap      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                cap = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            carry_q <= 1'b0;
            op      <= 2'b00;
            cout    <= 1'b0;
        end else if (accept) begin
            counter <= '0;
            carry_q <= cin;
            op      <= opSel;
            cout    <= 1'b0;
        end else if (cap) begin
            counter <= counter + 1'b1;
            carry_q <= carryOut;
            if (last) begin
                cout <= carryOut;
            end
        end
    end

`ifdef SERIAL_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (cap && last) begin
            ovf <= carry_q ^ carryOut;
        end
    end
`endif

    ula_bit_shreg #(.W(W)) u_sh_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .din   (opA),
        .shift (cap),
        .sin   (1'b0),
        .q     (sh_a)
    );

    ula_bit_shreg #(.W(W)) u_sh_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .din   (opB),
        .shift (cap),
        .sin   (1'b0),
        .q     (sh_b)
    );

    ula_bit_shreg #(.W(W)) u_result (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .din   ({W{1'b0}}),
        .shift (cap),
        .sin   (C),
        .q     (result)
    );

    assign unused_bits = ^{sh_a[W-1:1], sh_b[W-1:1]};

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign A       = busy & sh_a[0];
    assign B       = busy & sh_b[0];
    assign carryIn = busy & carry_q;

endmodule

// File: tb/tb_ula_serial_seq.sv
// tb/tb_ula_serial_seq.sv - directed self-checking bench with a behavioural 1-bit ALU
module tb_ula_serial_seq;
    import ula_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic [1:0]   opSel = OP_AND;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] result;
    logic         A, B, carryIn;
    logic [1:0]   op;
    logic         C, carryOut;
`ifdef SERIAL_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;
    int n;
    int seen;

    ula_serial_seq #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opA      (opA),
        .opB      (opB),
        .opSel    (opSel),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .A        (A),
        .B        (B),
        .carryIn  (carryIn),
        .op       (op),
        .C        (C),
        .carryOut (carryOut)
`ifdef SERIAL_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        C        = 1'b0;
        carryOut = 1'b0;
        case (op)
            OP_AND: C = A & B;
            OP_OR:  C = A | B;
            OP_ADD: begin
                C        = A ^ B ^ carryIn;
                carryOut = (A & B) | (carryIn & (A ^ B));
            end
            OP_XOR: C = A ^ B;
            default: C = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the start edge with start dropped.
    task automatic start_op(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci);
        opSel = sel;
        opA   = a;
        opB   = b;
        cin   = ci;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges until done is seen; cnt=1 is the cycle right after the start edge.
    task automatic wait_done(output int cnt);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        if (!done) cnt = -1;
    endtask

    initial begin
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'h00);
        chk("reset_abc", 32'({A, B, carryIn, cout}), 32'd0);
        chk("reset_op", 32'(op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ADD 0x5A + 0x3C
        start_op(OP_ADD, 8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        chk("t1_bit0_busy", 32'(busy), 32'd1);
        chk("t1_bit0_ab", 32'({A, B, carryIn}), 32'b000);
        chk("t1_op", 32'(op), 32'(OP_ADD));
        @(negedge clk);
        chk("t1_bit1_ab", 32'({A, B}), 32'b10);
        wait_done(n);
        chk("t1_latency", 32'(n + 2), 32'd9);
        chk("t1_result", 32'(result), 32'h96);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_busy_in_done", 32'(busy), 32'd0);
`ifdef SERIAL_OVF_EN
        chk("t1_ovf", 32'(ovf), 32'd1);
`endif
        repeat (3) @(negedge clk);
        chk("t1_hold_result", 32'(result), 32'h96);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_abc", 32'({A, B, carryIn}), 32'd0);

        // 2: ADD 0xFF + 0x01 wraps with carry
        start_op(OP_ADD, 8'hFF, 8'h01, 1'b0);
        wait_done(n);
        chk("t2_latency", 32'(n), 32'd9);
        chk("t2_result", 32'(result), 32'h00);
        chk("t2_cout", 32'(cout), 32'd1);
`ifdef SERIAL_OVF_EN
        chk("t2_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);

        // 3: ADD 0x7F + 0x01 signed overflow
        start_op(OP_ADD, 8'h7F, 8'h01, 1'b0);
        wait_done(n);
        chk("t3_result", 32'(result), 32'h80);
        chk("t3_cout", 32'(cout), 32'd0);
`ifdef SERIAL_OVF_EN
        chk("t3_ovf", 32'(ovf), 32'd1);
`endif
        @(negedge clk);

        // 4: AND then back-to-back OR started in the DONE cycle
        start_op(OP_AND, 8'hF0, 8'h3C, 1'b0);
        wait_done(n);
        chk("t4_and_result", 32'(result), 32'h30);
        chk("t4_and_cout", 32'(cout), 32'd0);
        start_op(OP_OR, 8'h0F, 8'h30, 1'b0);
        chk("t4_b2b_busy", 32'({busy, done}), 32'b10);
        chk("t4_b2b_op", 32'(op), 32'(OP_OR));
        wait_done(n);
        chk("t4_or_latency", 32'(n), 32'd9);
        chk("t4_or_result", 32'(result), 32'h3F);
        @(negedge clk);

        // 5: start during RUN is ignored
        start_op(OP_ADD, 8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        opSel = OP_AND;
        opA   = 8'hFF;
        opB   = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t5_op_kept", 32'(op), 32'(OP_ADD));
        wait_done(n);
        chk("t5_latency", 32'(n), 32'd6);
        chk("t5_result", 32'(result), 32'h46);
        @(negedge clk);

        // 6: async reset in the bit-4 cycle of an ADD
        start_op(OP_ADD, 8'hFF, 8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_result", 32'(result), 32'h00);
        chk("t6_abc", 32'({A, B, carryIn, done, cout}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("t6_no_done", 32'(seen), 32'd0);
        start_op(OP_ADD, 8'h01, 8'h02, 1'b1);
        wait_done(n);
        chk("t6_after_latency", 32'(n), 32'd9);
        chk("t6_after_result", 32'(result), 32'h04);
        @(negedge clk);

        // XOR with carry-in set: carry is irrelevant to XOR
        start_op(OP_XOR, 8'hA5, 8'hFF, 1'b1);
        wait_done(n);
        chk("t7_xor_result", 32'(result), 32'h5A);
        chk("t7_xor_cout", 32'(cout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
